// File: rtl/led_frame_ctrl.sv
// LED frame controller: streams NUM_LEDS colour words from RAM to an LED driver,
// scaling each by a global brightness and handshaking with the driver's rdy/nxt.
module led_frame_ctrl #(
  parameter int unsigned NUM_LEDS    = 64,
  parameter int unsigned TRIG_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned REFRESH_CYC = 1666666
) (
  input  logic        clk_100mhz,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        auto_en,
  input  logic [7:0]  brightness,
  output logic        mem_rd_en,
  output logic [7:0]  mem_addr,
  input  logic [23:0] mem_rdata,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        trig_out,
  input  logic        rdy_in,
  input  logic        nxt_in,
  output logic        busy,
  output logic        frame_done,
  output logic        skip,
  output logic        err
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > TRIG_LEN) ? TIMEOUT_CYC : TRIG_LEN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RefW   = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  localparam logic [CntW-1:0] TrigLast    = CntW'(TRIG_LEN - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [RefW-1:0] RefLast     = RefW'(REFRESH_CYC - 1);
  localparam logic [7:0]      IdxLast     = 8'(NUM_LEDS - 1);

  typedef enum logic [3:0] {
    StIdle,
    StWaitRdy,
    StFetch,
    StScale,
    StTrigHi,
    StTrigLo,
    StWaitNxt,
    StWaitLatch,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RefW-1:0] ref_q, ref_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      bright_q, bright_d;
  logic [7:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic            seen_nxt_q, seen_nxt_d;
  logic            frame_done_q, frame_done_d;
  logic            skip_q, skip_d;
  logic            err_q, err_d;
  logic            tick, start_req, timeout;

  assign tick      = auto_en && (ref_q == RefLast);
  assign start_req = frame_start || tick;
  assign timeout   = (cnt_q == TimeoutLast);

  always_comb begin
    ref_d = '0;
    if (auto_en) begin
      ref_d = tick ? '0 : ref_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bright_d     = bright_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    seen_nxt_d   = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    // Requests while a frame is in flight are dropped, not queued.
    skip_d       = start_req && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (start_req) begin
          bright_d = brightness;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (rdy_in)       state_d = StFetch;
        else if (timeout) state_d = StErr;
      end
      StFetch: state_d = StScale;
      StScale: begin
        // (c * (b + 1)) >> 8 keeps b = 255 an exact identity.
        red_d   = 8'((16'(mem_rdata[23:16]) * (16'(bright_q) + 16'd1)) >> 8);
        green_d = 8'((16'(mem_rdata[15:8])  * (16'(bright_q) + 16'd1)) >> 8);
        blue_d  = 8'((16'(mem_rdata[7:0])   * (16'(bright_q) + 16'd1)) >> 8);
        state_d = StTrigHi;
      end
      StTrigHi: begin
        if (cnt_q == TrigLast) state_d = StTrigLo;
      end
      StTrigLo: begin
        if (cnt_q == TrigLast) begin
          if (idx_q < IdxLast) begin
            idx_d   = idx_q + 1'b1;
            state_d = StWaitNxt;
          end else begin
            state_d = StWaitLatch;
          end
        end
      end
      StWaitNxt: begin
        if (nxt_in)       state_d = StFetch;
        else if (timeout) state_d = StErr;
      end
      StWaitLatch: begin
        // The driver frees its buffer first, then reports idle once latched.
        seen_nxt_d = seen_nxt_q || nxt_in;
        if (seen_nxt_d && rdy_in) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StErr) err_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || (state_q == StIdle)) cnt_d = '0;
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ref_q        <= '0;
      idx_q        <= '0;
      bright_q     <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      seen_nxt_q   <= 1'b0;
      frame_done_q <= 1'b0;
      skip_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_q        <= ref_d;
      idx_q        <= idx_d;
      bright_q     <= bright_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      seen_nxt_q   <= seen_nxt_d;
      frame_done_q <= frame_done_d;
      skip_q       <= skip_d;
      err_q        <= err_d;
    end
  end

  // Decoded straight from state so reset drops trig_out and busy immediately.
  assign trig_out   = (state_q == StTrigHi);
  assign busy       = (state_q != StIdle);
  assign mem_rd_en  = (state_q == StFetch);
  assign mem_addr   = idx_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign frame_done = frame_done_q;
  assign skip       = skip_q;
  assign err        = err_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl: small frame (3 LEDs), short timeout and
// refresh period, passive monitor capturing words, addresses and pulses.
module tb_led_frame_ctrl;

  localparam int unsigned NumLeds    = 3;
  localparam int unsigned TrigLen    = 4;
  localparam int unsigned TimeoutCyc = 1000;
  localparam int unsigned RefreshCyc = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        auto_en = 1'b0;
  logic [7:0]  brightness = 8'd0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [23:0] mem_rdata = 24'd0;
  logic [7:0]  red, green, blue;
  logic        trig_out;
  logic        rdy_in = 1'b1;
  logic        nxt_in = 1'b1;
  logic        busy, frame_done, skip, err;

  int checks = 0;
  int errors = 0;

  logic [23:0] ram [256];
  logic [23:0] exp_basic [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};

  led_frame_ctrl #(
    .NUM_LEDS   (NumLeds),
    .TRIG_LEN   (TrigLen),
    .TIMEOUT_CYC(TimeoutCyc),
    .REFRESH_CYC(RefreshCyc)
  ) dut (
    .clk_100mhz (clk),
    .reset_n    (rst_n),
    .frame_start(frame_start),
    .auto_en    (auto_en),
    .brightness (brightness),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .trig_out   (trig_out),
    .rdy_in     (rdy_in),
    .nxt_in     (nxt_in),
    .busy       (busy),
    .frame_done (frame_done),
    .skip       (skip),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Colour RAM with one clock of read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  // Passive monitor sampled on the falling edge.
  logic [23:0] words [$];
  logic [7:0]  addrs [$];
  longint      done_t [$];
  longint      cyc = 0;
  int          n_done = 0, n_skip = 0, hi_bad = 0, gap_bad = 0;
  int          hi_len = 0, lo_len = 0;
  logic        trig_prev = 1'b0;
  bit          in_gap = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_done) begin n_done++; done_t.push_back(cyc); end
    if (skip) n_skip++;
    if (mem_rd_en) addrs.push_back(mem_addr);
    if (trig_out && !trig_prev) begin
      words.push_back({red, green, blue});
      // Low gap = TRIG_LO(4) + WAIT_NXT(1) + FETCH(1) + SCALE(1) with nxt_in held high.
      if (in_gap && lo_len != 7) gap_bad++;
      hi_len = 0;
    end
    if (!trig_out && trig_prev) begin
      if (hi_len != TrigLen) hi_bad++;
      lo_len = 0;
      in_gap = 1'b1;
    end
    if (trig_out) hi_len++; else lo_len++;
    if (!busy) in_gap = 1'b0;
    trig_prev = trig_out;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget);
    int c = 0;
    while (words.size() < target && c < budget) begin tick(1); c++; end
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin tick(1); c++; end
  endtask

  task automatic load_basic();
    ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF;
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({trig_out, mem_rd_en, busy, frame_done, skip, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {trig_out, mem_rd_en, busy, frame_done, skip, err});
    end
    checks++;
    if ({red, green, blue, mem_addr} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 00000000", {red, green, blue, mem_addr});
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    int w0, a0, d0, h0, g0;
    logic [23:0] act;
    load_basic();
    brightness = 8'd255;
    rdy_in = 1'b0; nxt_in = 1'b1;
    w0 = words.size(); a0 = addrs.size(); d0 = n_done; h0 = hi_bad; g0 = gap_bad;
    pulse_start();
    tick(5);
    checks++;
    if (busy !== 1'b1 || addrs.size() != a0) begin
      errors++;
      $display("FAIL basic_wait_rdy busy=%b reads=%0d want busy=1 reads=0", busy, addrs.size() - a0);
    end
    rdy_in = 1'b1;
    wait_words(w0 + 1, 50);
    rdy_in = 1'b0;
    wait_words(w0 + 3, 100);
    tick(20);
    checks++;
    if (n_done != d0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_latch_hold done=%0d busy=%b want done=0 busy=1", n_done - d0, busy);
    end
    rdy_in = 1'b1;
    wait_done(d0 + 1, 10);
    tick(5);
    checks++;
    if (n_done != d0 + 1) begin
      errors++; $display("FAIL basic_done got %0d pulses want 1", n_done - d0);
    end
    for (int i = 0; i < 3; i++) begin
      act = (words.size() > w0 + i) ? words[w0 + i] : 24'hxxxxxx;
      checks++;
      if (act !== exp_basic[i]) begin
        errors++; $display("FAIL basic_word%0d got %h want %h", i, act, exp_basic[i]);
      end
    end
    checks++;
    if (words.size() != w0 + 3) begin
      errors++; $display("FAIL basic_word_count got %0d want 3", words.size() - w0);
    end
    checks++;
    if (addrs.size() != a0 + 3 || addrs[a0] !== 8'd0 || addrs[a0 + 1] !== 8'd1 ||
        addrs[a0 + 2] !== 8'd2) begin
      errors++; $display("FAIL basic_addrs got %0d reads want 0,1,2", addrs.size() - a0);
    end
    checks++;
    if (hi_bad != h0 || gap_bad != g0) begin
      errors++;
      $display("FAIL basic_trig_timing hi_bad=%0d gap_bad=%0d want 0 0", hi_bad - h0, gap_bad - g0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle busy=%b want 0", busy); end
  endtask

  task automatic test_scaling();
    int w0, d0;
    logic [23:0] exp_s [3] = '{24'h407F00, 24'h7F7F7F, 24'h000040};
    logic [23:0] act;
    ram[0] = 24'h80FF01; ram[1] = 24'hFFFFFF; ram[2] = 24'h000080;
    rdy_in = 1'b1; nxt_in = 1'b1;
    brightness = 8'd127;
    w0 = words.size(); d0 = n_done;
    pulse_start();
    brightness = 8'd0;  // must not affect the frame already started
    wait_done(d0 + 1, 100);
    for (int i = 0; i < 3; i++) begin
      act = (words.size() > w0 + i) ? words[w0 + i] : 24'hxxxxxx;
      checks++;
      if (act !== exp_s[i]) begin
        errors++; $display("FAIL scale127_word%0d got %h want %h", i, act, exp_s[i]);
      end
    end
    tick(2);
    w0 = words.size(); d0 = n_done;
    pulse_start();
    wait_done(d0 + 1, 100);
    for (int i = 0; i < 3; i++) begin
      act = (words.size() > w0 + i) ? words[w0 + i] : 24'hxxxxxx;
      checks++;
      if (act !== 24'h000000) begin
        errors++; $display("FAIL scale0_word%0d got %h want 000000", i, act);
      end
    end
    tick(2);
  endtask

  task automatic test_timeout();
    int w0, d0, n, c;
    load_basic();
    brightness = 8'd255;
    rdy_in = 1'b1; nxt_in = 1'b0;
    w0 = words.size(); d0 = n_done;
    pulse_start();
    wait_words(w0 + 1, 50);
    c = 0;
    @(negedge clk);
    while (trig_out && c < 20) begin @(negedge clk); c++; end
    // First TRIG_LO negedge: expect 4 TRIG_LO + 1000 WAIT_NXT + 1 ERR busy cycles.
    n = 0;
    while (busy && n < 2000) begin n++; @(negedge clk); end
    checks++;
    if (n != 1005) begin errors++; $display("FAIL timeout_len got %0d want 1005", n); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_err err=%b want 1", err); end
    tick(1);
    checks++;
    if (n_done != d0 || words.size() != w0 + 1) begin
      errors++;
      $display("FAIL timeout_no_done done=%0d words=%0d want 0 1", n_done - d0, words.size() - w0);
    end
    tick(5);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL timeout_idle busy=%b err=%b want 0 1", busy, err);
    end
    nxt_in = 1'b1;
  endtask

  task automatic test_skip();
    int w0, d0, s0;
    logic [23:0] act;
    w0 = words.size(); d0 = n_done; s0 = n_skip;
    pulse_start();
    tick(2);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL skip_err_clear err=%b want 0", err); end
    wait_words(w0 + 2, 100);
    pulse_start();
    wait_done(d0 + 1, 100);
    tick(10);
    checks++;
    if (n_skip != s0 + 1) begin
      errors++; $display("FAIL skip_pulse got %0d want 1", n_skip - s0);
    end
    checks++;
    if (n_done != d0 + 1 || words.size() != w0 + 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL skip_frame done=%0d words=%0d busy=%b want 1 3 0",
               n_done - d0, words.size() - w0, busy);
    end
    for (int i = 0; i < 3; i++) begin
      act = (words.size() > w0 + i) ? words[w0 + i] : 24'hxxxxxx;
      checks++;
      if (act !== exp_basic[i]) begin
        errors++; $display("FAIL skip_word%0d got %h want %h", i, act, exp_basic[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0, a0, d0;
    w0 = words.size();
    pulse_start();
    wait_words(w0 + 1, 50);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (trig_out !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async trig=%b busy=%b want 0 0", trig_out, busy);
    end
    checks++;
    if ({red, green, blue} !== 24'h0) begin
      errors++; $display("FAIL rstmid_rgb got %h want 000000", {red, green, blue});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = n_done;
    tick(5);
    checks++;
    if (n_done != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", n_done - d0); end
    a0 = addrs.size(); w0 = words.size();
    pulse_start();
    wait_done(d0 + 1, 100);
    checks++;
    if (addrs.size() != a0 + 3 || addrs[a0] !== 8'd0 || addrs[a0 + 1] !== 8'd1 ||
        addrs[a0 + 2] !== 8'd2 || n_done != d0 + 1) begin
      errors++;
      $display("FAIL rstmid_refetch reads=%0d done=%0d want 3 reads from 0 and 1 done",
               addrs.size() - a0, n_done - d0);
    end
    tick(3);
  endtask

  task automatic test_auto();
    int w0, d0, s0;
    longint dt;
    w0 = words.size(); d0 = n_done; s0 = n_skip;
    auto_en = 1'b1;
    // First tick is sampled on the 20000th rising edge after auto_en; collide frame_start with it.
    tick(RefreshCyc - 1);
    pulse_start();
    wait_done(d0 + 1, 100);
    tick(5);
    checks++;
    if (n_done != d0 + 1 || words.size() != w0 + 3 || n_skip != s0) begin
      errors++;
      $display("FAIL auto_collide done=%0d words=%0d skip=%0d want 1 3 0",
               n_done - d0, words.size() - w0, n_skip - s0);
    end
    wait_done(d0 + 2, RefreshCyc + 200);
    dt = (done_t.size() >= 2) ? done_t[done_t.size() - 1] - done_t[done_t.size() - 2] : 0;
    checks++;
    if (n_done != d0 + 2 || dt != RefreshCyc) begin
      errors++; $display("FAIL auto_period done=%0d dt=%0d want 2 20000", n_done - d0, dt);
    end
    auto_en = 1'b0;
    tick(RefreshCyc + 500);
    checks++;
    if (n_done != d0 + 2 || busy !== 1'b0) begin
      errors++; $display("FAIL auto_off done=%0d busy=%b want 2 0", n_done - d0, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 24'h0;
    test_reset();
    test_basic();
    test_scaling();
    test_timeout();
    test_skip();
    test_reset_mid();
    test_auto();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
